kurm_fetch_unit: RTL
====================

# kurm_fetch_unit

Instruction fetch and program-counter stage of the KURM RISC core, directly upstream of `KURM_controller`. Fetches 16-bit instructions from instruction memory over a req/ack handshake and holds them in an instruction register. Presents the 4-bit opcode as the controller's `s0..s3` inputs, then waits for the execute stage to finish. Computes the next PC from the controller's Jump (Out1) and Branch (Out2) signals and the ALU zero flag.

## Interface

Parameters:
- `ADDR_W`, 8: PC and instruction-memory word-address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `imem_req`  out  1: fetch request; high exactly while in FETCH.
- `imem_addr`  out  ADDR_W: word address; equals `pc`.
- `imem_ack`  in  1: memory response; `imem_rdata` is valid when sampled high with `imem_req`.
- `imem_rdata`  in  16: instruction word.
- `instr`  out  16: instruction register.
- `s0, s1, s2, s3`  out  1 each: opcode, `s0`=instr[15] … `s3`=instr[12]; feeds the controller directly.
- `instr_valid`  out  1: one-cycle pulse in DECODE.
- `jump`  in  1: controller Out1.
- `branch`  in  1: controller Out2 (BNE).
- `alu_zero`  in  1: ALU result-zero flag.
- `exec_done`  in  1: execute/writeback complete; one-cycle pulse.
- `pc`  out  ADDR_W: current program counter.

## Operation

- Instruction format:
  - [15:12] opcode.
  - Jump target is instr[ADDR_W-1:0].
  - Branch offset is instr[5:0], sign-extended to ADDR_W.
  - PC is word-addressed.
- Reset values: `pc`=RESET_PC, `imem_addr`=RESET_PC, `imem_req`=0, `instr`=16'h0000, `s0..s3`=0, `instr_valid`=0, state=IDLE.
- FSM states are IDLE, FETCH, DECODE, EXEC.
  - IDLE → FETCH unconditionally. IDLE is entered only from reset.
  - FETCH: `imem_req`=1 and the address is held stable. On `imem_ack`=1 the unit loads `instr`←`imem_rdata` and goes to DECODE. Otherwise it stays in FETCH, with no timeout.
  - DECODE: `instr_valid`=1 and the opcode is stable. Always → EXEC.
  - EXEC: wait for `exec_done`. On `exec_done`=1 the unit loads `pc`←next_pc and goes to FETCH.
- next_pc is evaluated from `jump`/`branch`/`alu_zero` sampled on the `exec_done` edge:
  - If `jump`=1: instr[ADDR_W-1:0]. Jump has priority over branch.
  - Else if `branch`=1 and `alu_zero`=0 (BNE taken): pc+1+sext(instr[5:0]).
  - Else: pc+1.
- All PC arithmetic is modulo 2^ADDR_W: wrap-around is silent and there is no trap.
- Opcodes 1010–1111 get no special handling here; the unit fetches and sequences them normally.
- `imem_ack` outside FETCH is ignored. `exec_done` outside EXEC is ignored.
- Assertion of `reset_n` in any state, including mid-fetch with an ack pending, immediately forces the reset values. An ack arriving during or after reset is discarded.

## Timing

- `imem_req`, `instr_valid` and `s0..s3` are decoded/registered from state. They are never combinational from inputs.
- Zero-wait memory: ack in the first FETCH cycle is legal, so FETCH lasts 1 cycle.
- Minimum instruction period is 3 cycles: FETCH, DECODE, EXEC with `exec_done` in its first cycle.
- Ack on edge N:
  - `instr` and `s0..s3` update at N.
  - `instr_valid` is high during cycle N..N+1.
  - The controller registers its outputs at edge N+1, so `jump`/`branch` are valid throughout EXEC.
- The first `imem_req` rises one cycle after `reset_n` deassertion (IDLE lasts 1 cycle).
- `pc` changes only at the `exec_done` edge. `imem_addr` tracks `pc` with no additional latency.

## Structure

- Shared package `kurm_pkg` holds:
  - `INSTR_W`=16.
  - Opcode constants OP_ADD=4'b0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_SLT=0100, OP_LW=0101, OP_SW=0110, OP_BNE=0111, OP_JMP=1000, OP_ADDU=1001.
  - The fetch FSM state enumeration.
- One sub-module, `kurm_next_pc`: combinational next-PC mux and adder (inputs pc, instr, jump, branch, alu_zero; output next_pc).

## Test plan

- Reset then zero-wait ack, rdata=16'h0123 → `imem_req` rises 1 cycle after release; `instr`=16'h0123; s0..s3=0000; `instr_valid` pulses once; `pc`=1 after `exec_done`.
- Memory holds ack low 4 cycles → `imem_req` and `imem_addr` stable for 5 cycles; no `instr_valid` before ack.
- At pc=8'h10, instr=16'h8042 with `jump`=1, `branch`=1 → `pc`=8'h42 (jump priority).
- At pc=8'h20, BNE with offset 6'b111100 (−4), `branch`=1:
  - `alu_zero`=0 → `pc`=8'h1D.
  - `alu_zero`=1 → `pc`=8'h21.
- At pc=8'hFF, non-branch instruction → `pc` wraps to 8'h00; BNE at 8'hFE with offset +3 → `pc`=8'h02.
- `reset_n` low in FETCH with ack arriving the same cycle → all reset values; `instr` stays 0; a spurious `exec_done` in IDLE/FETCH leaves `pc` unchanged.

Source files
------------

// File: rtl/kurm_pkg.sv
// Purpose : shared constants, opcodes and fetch FSM states for the KURM core.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package kurm_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_ADDU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/kurm_next_pc.sv
// Purpose : next-PC selection: jump target, taken BNE (pc+1+sext offset) or pc+1.
// Latency : purely combinational.
// Backpr. : none; result is consumed by the fetch unit only on the exec_done edge.
// Ports   : pc_i current PC, instr_i instruction register, jump_i/branch_i from the
//           controller, alu_zero_i ALU zero flag, next_pc_o selected next PC.
module kurm_next_pc
  import kurm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               jump_i,
  input  logic               branch_i,
  input  logic               alu_zero_i,
  output logic [ADDR_W-1:0]  next_pc_o
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_tgt;

  // All arithmetic is ADDR_W wide, so wrap-around past the top of memory is free.
  assign seq_pc  = pc_i + ADDR_W'(1);
  assign br_off  = ADDR_W'($signed(instr_i[5:0]));
  assign jmp_tgt = instr_i[ADDR_W-1:0];

  // Jump wins over branch; BNE is taken only when the ALU result was non-zero.
  always_comb begin
    next_pc_o = seq_pc;
    if (jump_i) begin
      next_pc_o = jmp_tgt;
    end else if (branch_i && !alu_zero_i) begin
      next_pc_o = seq_pc + br_off;
    end
  end

  // Instruction bits above the address width play no part in PC selection.
  if (ADDR_W < INSTR_W) begin : g_unused_hi
    logic unused_instr_hi;
    assign unused_instr_hi = ^instr_i[INSTR_W-1:ADDR_W];
  end

endmodule

// File: rtl/kurm_fetch_unit.sv
// Purpose : KURM fetch/PC stage: fetches a 16-bit instruction, presents its opcode
//           to the controller, waits for execute, then advances the PC.
// Latency : 3 cycles minimum per instruction (FETCH, DECODE, EXEC).
// Backpr. : FETCH holds req/addr until imem_ack; EXEC holds until exec_done.
// Ports   : clock/reset_n; imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
//           instr, s0..s3 (opcode MSB first), instr_valid decode pulse; jump, branch,
//           alu_zero, exec_done from controller/datapath; pc current program counter.
module kurm_fetch_unit
  import kurm_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic               s3,
  output logic               instr_valid,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_zero,
  input  logic               exec_done,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  next_pc;

  kurm_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (instr_q),
    .jump_i     (jump),
    .branch_i   (branch),
    .alu_zero_i (alu_zero),
    .next_pc_o  (next_pc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // imem_ack only matters in FETCH and exec_done only in EXEC; elsewhere both
  // fall through to the hold defaults.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake/decode outputs come straight from registered state, never from inputs.
  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_DECODE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign s0          = instr_q[15];
  assign s1          = instr_q[14];
  assign s2          = instr_q[13];
  assign s3          = instr_q[12];

endmodule
